// File: rtl/parity_frame_tx_pkg.sv
// Shared types and helpers for the parity framed serial transmitter.
package parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Word handshake in, serial line and frame status out.
interface parity_frame_tx_if #(
  parameter int unsigned DATA_W = 3
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_out;
  logic              busy;
  logic              done;

  modport master (output in_data, in_valid, input in_ready, tx_out, busy, done);
  modport slave  (input in_data, in_valid, output in_ready, tx_out, busy, done);
endinterface

// File: rtl/parity_frame_tx_parity_calc.sv
// Even-parity bit for a data word: set when the word holds an odd number of ones.
module parity_calc #(
  parameter int unsigned DATA_W = 3
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_c_o
);
  assign parity_c_o = ^data_i;
endmodule

// File: rtl/parity_frame_tx.sv
// Serialises accepted words as start, data LSB-first, even parity and stop bits.
module parity_frame_tx
  import parity_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  parity_frame_tx_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IDX_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              parity_c;
  logic              last_tick_c;
  logic              ready_c;
  logic              accept_c;

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .data_i     (bus.in_data),
    .parity_c_o (parity_c)
  );

  assign last_tick_c = (cnt_q == CNT_LAST);
  assign ready_c     = (state_q == IDLE) || ((state_q == STOP) && last_tick_c);
  assign accept_c    = bus.in_valid && ready_c;

  assign bus.in_ready = ready_c;
  assign bus.tx_out   = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Next state, counters and the registered line/status values they imply.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          sh_d    = bus.in_data;
          par_d   = parity_c;
        end
      end
      START: begin
        cnt_d = last_tick_c ? '0 : cnt_q + CNT_W'(1);
        if (last_tick_c) state_d = DATA;
      end
      DATA: begin
        cnt_d = last_tick_c ? '0 : cnt_q + CNT_W'(1);
        if (last_tick_c) begin
          sh_d = sh_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        cnt_d = last_tick_c ? '0 : cnt_q + CNT_W'(1);
        if (last_tick_c) state_d = STOP;
      end
      STOP: begin
        cnt_d = last_tick_c ? '0 : cnt_q + CNT_W'(1);
        if (last_tick_c) begin
          // A word offered in the last stop cycle starts the next frame with no idle gap.
          if (accept_c) begin
            state_d = START;
            idx_d   = '0;
            sh_d    = bus.in_data;
            par_d   = parity_c;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: table of words, frame scoreboard, corner sequences.
module tb_parity_frame_tx;

  localparam int DW    = 3;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 3) * CPB;

  typedef struct packed {
    logic [2:0] data;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_frame_tx_if #(.DATA_W(3)) bus ();
  parity_frame_tx_if #(.DATA_W(8)) bus8 ();

  parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   frames_done = 0;
  vec_t sb_q[$];
  int   done_cyc[$];

  int         pos = 0;
  bit         active = 0;
  bit         shape_bad = 0;
  vec_t       cur;
  logic [5:0] exp_v;
  logic [5:0] got_v;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame monitor: pops the expected word when a frame starts and checks every cycle of it.
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      pos    = 0;
    end else begin
      if (!active && bus.busy === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: frame started with got no queued word expected one");
          cur = '0;
        end else begin
          cur = sb_q.pop_front();
        end
        active    = 1;
        pos       = 0;
        shape_bad = 0;
        got_v     = '0;
        exp_v     = {1'b1, cur.par, cur.data, 1'b0};
      end
      if (active) begin
        got_v[pos / CPB] = bus.tx_out;
        if (bus.tx_out !== exp_v[pos / CPB] || bus.busy !== 1'b1 ||
            bus.done !== (pos == FRAME - 1))
          shape_bad = 1;
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
        if (pos == FRAME - 1) begin
          check("frame_bits", 32'(got_v), 32'(exp_v));
          check("frame_shape", 32'(shape_bad), 32'd0);
          active = 0;
          frames_done++;
        end
        pos++;
      end else if (bus.done !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL stray_done: got done=%b expected 0 outside a frame", bus.done);
      end
    end
  end

  task automatic send(input logic [2:0] d, input logic p);
    bit   ok = 0;
    vec_t v;
    v.data = d;
    v.par  = p;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (bus.in_ready === 1'b1) begin
        sb_q.push_back(v);
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("accept", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", 32'(frames_done), 32'(target));
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl[7];
    int          d0;
    int          gap;
    logic [10:0] got8;
    logic [10:0] exp8 = 11'b10101001010;
    bit          shape8_bad = 0;

    tbl[0] = '{data: 3'b101, par: 1'b0};
    tbl[1] = '{data: 3'b111, par: 1'b1};
    tbl[2] = '{data: 3'b000, par: 1'b0};
    tbl[3] = '{data: 3'b110, par: 1'b0};
    tbl[4] = '{data: 3'b011, par: 1'b0};
    tbl[5] = '{data: 3'b010, par: 1'b1};
    tbl[6] = '{data: 3'b001, par: 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus8.in_valid = 1'b0;
    bus8.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx_out), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_tx", 32'(bus.tx_out), 32'd1);
    check("idle_ready", 32'(bus.in_ready), 32'd1);

    // Single frames from the table, idle between them.
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].data, tbl[i].par);
      bus.in_valid = 1'b0;
      wait_frames(i + 1);
    end

    // Back-to-back: second word accepted in the last stop cycle.
    d0 = done_cyc.size();
    send(tbl[3].data, tbl[3].par);
    send(tbl[4].data, tbl[4].par);
    bus.in_valid = 1'b0;
    check("b2b_tx", 32'(bus.tx_out), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_frames(5);
    check("b2b_done_count", 32'(done_cyc.size() - d0), 32'd2);
    gap = (done_cyc.size() >= d0 + 2) ? done_cyc[d0 + 1] - done_cyc[d0] : -1;
    check("b2b_done_gap", 32'(gap), 32'(FRAME));

    // Input word churns after accept; frame must still carry the accepted word.
    send(tbl[5].data, tbl[5].par);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bus.in_data = 3'($urandom);
      @(negedge clk);
    end
    wait_frames(6);

    // Reset in the middle of data bit 1.
    send(3'b111, 1'b1);
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", 32'(bus.tx_out), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_frames", 32'(frames_done), 32'd6);
    send(tbl[6].data, tbl[6].par);
    bus.in_valid = 1'b0;
    wait_frames(7);

    // Wide word, one clock per bit.
    check("w8_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_data  = 8'hA5;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    got8 = '0;
    for (int i = 0; i < 11; i++) begin
      got8[i] = bus8.tx_out;
      if (bus8.busy !== 1'b1 || bus8.done !== (i == 10)) shape8_bad = 1;
      @(negedge clk);
    end
    check("w8_frame", 32'(got8), 32'(exp8));
    check("w8_shape", 32'(shape8_bad), 32'd0);
    check("w8_idle_busy", 32'(bus8.busy), 32'd0);
    check("w8_idle_tx", 32'(bus8.tx_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
